// File: rtl/led_dbg_pkg.sv
// Shared display-mode definitions for the LED-bar debug multiplexer.
package led_dbg_pkg;

    typedef enum logic [1:0] {
        MODE_LIVE    = 2'b00,
        MODE_CAPTURE = 2'b01,
        MODE_SCAN    = 2'b10,
        MODE_FREEZE  = 2'b11
    } mode_t;

endpackage

// File: rtl/led_scan_timer.sv
// Auto-scan prescaler and channel index; idx advances once every SCAN_DIV enabled cycles.
module led_scan_timer #(
    parameter int NCH      = 4,
    parameter int SELW     = $clog2(NCH),
    parameter int SCAN_DIV = 25_000_000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic            load,
    input  logic [SELW-1:0] loadIdx,
    output logic [SELW-1:0] idx
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] prescaler;
    logic          lastTick;

    assign lastTick = (prescaler == PW'(SCAN_DIV - 1));

    // A load restarts the dwell from zero so the first channel gets a full period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            idx       <= '0;
        end else if (load) begin
            prescaler <= '0;
            idx       <= loadIdx;
        end else if (enable) begin
            if (lastTick) begin
                prescaler <= '0;
                idx       <= (idx == SELW'(NCH - 1)) ? '0 : idx + SELW'(1);
            end else begin
                prescaler <= prescaler + PW'(1);
            end
        end
    end

endmodule

// File: rtl/led_debug_mux.sv
// Drives the SBC LED bar from one of NCH internal buses: live, captured, auto-scanned or frozen.
module led_debug_mux
    import led_dbg_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NCH      = 4,
    parameter int SELW     = $clog2(NCH),
    parameter int SCAN_DIV = 25_000_000,
    parameter bit INVERT   = 1'b1
) (
    input  logic                 pll0_100MHz,
    input  logic                 reset,
    input  logic [NCH*WIDTH-1:0] chData,
    input  logic [NCH-1:0]       chStrobe,
    input  logic [SELW-1:0]      sw,
    input  logic [1:0]           mode,
    output logic [WIDTH-1:0]     LEDoutData,
    output logic [SELW-1:0]      curCh
);

    mode_t            modeCur;
    mode_t            prevMode;
    logic [SELW-1:0]  sel;
    logic [SELW-1:0]  scanIdx;
    logic [SELW-1:0]  showIdx;
    logic [WIDTH-1:0] d;
    logic             hold;
    logic             enterScan;
    logic [WIDTH-1:0] liveCh [NCH];
    logic [WIDTH-1:0] cap    [NCH];

    assign modeCur   = mode_t'(mode);
    assign enterScan = (modeCur == MODE_SCAN) && (prevMode != MODE_SCAN);

    // Out-of-range switch settings fall back to the last channel.
    assign sel = (int'(sw) < NCH) ? sw : SELW'(NCH - 1);

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            liveCh[i] = chData[i*WIDTH +: WIDTH];
        end
    end

    // Strobes are honoured in every mode so FREEZE can still collect fresh snapshots.
    always_ff @(posedge pll0_100MHz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                cap[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (chStrobe[i]) begin
                    cap[i] <= chData[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge pll0_100MHz or posedge reset) begin
        if (reset) begin
            prevMode <= MODE_LIVE;
        end else begin
            prevMode <= modeCur;
        end
    end

    led_scan_timer #(
        .NCH      (NCH),
        .SELW     (SELW),
        .SCAN_DIV (SCAN_DIV)
    ) scanTimer (
        .clock   (pll0_100MHz),
        .reset   (reset),
        .enable  (modeCur == MODE_SCAN),
        .load    (enterScan),
        .loadIdx (sel),
        .idx     (scanIdx)
    );

    always_comb begin
        d       = '0;
        showIdx = sel;
        hold    = 1'b0;
        case (modeCur)
            MODE_LIVE: begin
                d       = liveCh[sel];
                showIdx = sel;
            end
            MODE_CAPTURE: begin
                d       = cap[sel];
                showIdx = sel;
            end
            MODE_SCAN: begin
                d       = cap[scanIdx];
                showIdx = scanIdx;
            end
            MODE_FREEZE: begin
                hold    = 1'b1;
            end
            default: begin
                hold    = 1'b1;
            end
        endcase
    end

    // Reset leaves every LED dark regardless of drive polarity.
    always_ff @(posedge pll0_100MHz or posedge reset) begin
        if (reset) begin
            LEDoutData <= INVERT ? '1 : '0;
            curCh      <= '0;
        end else if (!hold) begin
            LEDoutData <= INVERT ? ~d : d;
            curCh      <= showIdx;
        end
    end

endmodule

// File: doc/led_debug_mux.md
# led_debug_mux

Parametrised LED-bar debug multiplexer that drives the active-low SBC LED bar from one of NCH internal FPGA buses. Each channel may be shown live, as a strobe-captured snapshot, in a timed auto-scan across all channels, or frozen. Its inputs are the CPU data-out and data-in buses and the output port registers. Its output goes directly to the SBC LED driver pins.

## Interface
- WIDTH, 8: bits per channel and LED bar width.
- NCH, 4: number of monitored channels (>= 2).
- SELW, $clog2(NCH): width of the channel-select input.
- SCAN_DIV, 25_000_000: clock cycles per channel in auto-scan (0.25 s at 100 MHz, >= 2).
- INVERT, 1: 1 means the LEDs are active-low, so the output is the complement of the data.

- pll0_100MHz  in  1  sole clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- chData  in  NCH*WIDTH  channel buses; channel i occupies bits [i*WIDTH +: WIDTH].
- chStrobe  in  NCH  per-channel capture qualifier (e.g. a port-write or bus-valid pulse), level-sensitive per cycle.
- sw  in  SELW  channel select from the front-panel switches.
- mode  in  2  display mode: 00 LIVE, 01 CAPTURE, 10 SCAN, 11 FREEZE.
- LEDoutData  out  WIDTH  LED drive, registered.
- curCh  out  SELW  index of the channel currently shown, registered.

## Operation
- Channel select:
  - sel = sw when sw < NCH, otherwise NCH-1.
  - Out-of-range select therefore shows the last channel.
- Capture registers cap[i]:
  - Each cycle chStrobe[i]=1, cap[i] <= chData[i].
  - Captures happen in every mode, FREEZE included.
- Display value d per mode:
  - LIVE: d = chData[sel], curCh = sel.
  - CAPTURE: d = cap[sel], curCh = sel.
  - SCAN: d = cap[scanIdx], curCh = scanIdx.
  - FREEZE: LEDoutData and curCh hold their values; sw is ignored.
- Output: LEDoutData <= INVERT ? ~d : d.
- Scan timer (prescaler plus index):
  - In SCAN, the prescaler counts 0..SCAN_DIV-1.
  - In the cycle where it equals SCAN_DIV-1, it wraps to 0 and scanIdx advances. scanIdx wraps from NCH-1 to 0.
  - On entering SCAN (mode was not SCAN in the previous cycle), the prescaler is set to 0 and scanIdx to sel.
  - Outside SCAN, the prescaler and scanIdx hold.
- Reset, asynchronous:
  - cap[i] = 0.
  - prescaler = 0, scanIdx = 0, curCh = 0.
  - LEDoutData = all ones if INVERT=1, all zeros if INVERT=0 (all LEDs dark).
- A mode change takes effect on the next clock edge. There are no illegal mode values.

## Timing
- LIVE latency: chData change at edge t appears on LEDoutData after edge t+1.
- CAPTURE latency: strobe sampled at edge t, cap valid after t; LED updates after t+1 (2 edges from data to LED).
- Strobe coincident with FREEZE: cap updates, LED unchanged. Leaving FREEZE to CAPTURE shows the new cap after one edge.
- SCAN dwell: exactly SCAN_DIV cycles per channel. The first dwell after entry is also SCAN_DIV cycles.
- Reset asserted mid-scan: all state clears immediately.
  - After release in SCAN mode, scanIdx is set from sel on the first edge, because the mode register resets to non-SCAN.
- Registered previous mode resets to LIVE (00).

## Structure
- Shared package led_dbg_pkg holds the mode constants (MODE_LIVE, MODE_CAPTURE, MODE_SCAN, MODE_FREEZE) and the 2-bit mode typedef.
- One sub-module, led_scan_timer:
  - Contains the prescaler and scanIdx.
  - Inputs: enable, load, loadIdx.
  - Output: idx.
- The top level holds the capture array, select clamp, output register and curCh.

## Test plan
- Reset, defaults (WIDTH=8, NCH=4, INVERT=1) -> LEDoutData=8'hFF and curCh=0 during reset and immediately after release.
- LIVE, sw=1, chData ch1=8'hA5 -> LEDoutData=8'h5A one edge later. Then sw=3 with ch3=8'h0F -> 8'hF0.
- CAPTURE, sw=2:
  - chData ch2=8'h3C with chStrobe[2] high for 1 cycle, then ch2=8'hFF with no strobe -> LEDoutData=8'hC3 two edges after the strobe, and it stays 8'hC3.
- SCAN with SCAN_DIV=4, cap={8'h01,8'h02,8'h04,8'h08}, sw=1 at entry:
  - curCh sequence 1,2,3,0,1 changing every 4 cycles.
  - LEDoutData equals ~cap[curCh].
- FREEZE with a concurrent chStrobe[0] on 8'h77 at sw=0 -> LED holds its prior value. Switching to CAPTURE -> LEDoutData=8'h88 after one edge.
- NCH=3 (SELW=2), sw=3, INVERT=0 -> channel 2 is shown and curCh=2. Separately, asserting reset mid-scan -> immediate LEDoutData=0 and curCh=0.
